// File: rtl/updown_seq_pkg.sv
// rtl/updown_seq_pkg.sv - state encodings, mode codes and mode decode for updown_sequencer
package updown_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_RISE     = 3'd2;
    localparam logic [2:0] ST_DWELL_HI = 3'd3;
    localparam logic [2:0] ST_FALL     = 3'd4;
    localparam logic [2:0] ST_DWELL_LO = 3'd5;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // Invalid limits freeze the sweep states at HOLD; IDLE/CLEAR are unaffected.
    function automatic logic [1:0] state_mode(input logic [2:0] st, input logic lim_err);
        logic [1:0] m;
        m = MODE_HOLD;
        case (st)
            ST_CLEAR: m = MODE_CLEAR;
            ST_RISE:  m = lim_err ? MODE_HOLD : MODE_UP;
            ST_FALL:  m = lim_err ? MODE_HOLD : MODE_DOWN;
            default:  m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/updown_sequencer_tick_gen.sv
// rtl/updown_sequencer_tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] div_cnt;

    // tick is registered one count early so it lands on cycle TICK_DIV-1 after reset release
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == PRE_LAST);
        end
    end

endmodule

// File: rtl/updown_sequencer.sv
// rtl/updown_sequencer.sv - up/down sweep sequencer for the LED counter; SEQ_CYCLE_COUNT_EN adds round-trip counter output cycles
module updown_sequencer
    import updown_seq_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        run,
    input  logic        clear_req,
    input  logic [7:0]  hi_lim,
    input  logic [7:0]  lo_lim,
    input  logic [3:0]  dwell,
    input  logic [7:0]  count,
    output logic        tick,
    output logic [1:0]  mode,
    output logic [2:0]  state,
    output logic        err
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0] cycles
`endif
);

    logic [2:0] state_d;
    logic [3:0] dwell_q;
    logic [3:0] dwell_d;
    logic       err_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .tick       (tick)
    );

    always_comb begin
        state_d = state;
        dwell_d = dwell_q;
        err_d   = (lo_lim >= hi_lim);
        if (clear_req) begin
            state_d = ST_CLEAR;
        end else if (state == ST_CLEAR) begin
            if (tick)
                state_d = run ? ST_RISE : ST_IDLE;
        end else if (!run) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_d = ST_CLEAR;
                ST_RISE: begin
                    if (!err && count >= hi_lim) begin
                        state_d = ST_DWELL_HI;
                        dwell_d = dwell;
                    end
                end
                ST_FALL: begin
                    if (!err && count <= lo_lim) begin
                        state_d = ST_DWELL_LO;
                        dwell_d = dwell;
                    end
                end
                ST_DWELL_HI, ST_DWELL_LO: begin
                    // An exhausted dwell leaves without waiting for a tick
                    if (!err) begin
                        if (dwell_q == 4'd0)
                            state_d = (state == ST_DWELL_HI) ? ST_FALL : ST_RISE;
                        else if (tick)
                            dwell_d = dwell_q - 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state   <= ST_IDLE;
            mode    <= MODE_HOLD;
            err     <= 1'b0;
            dwell_q <= 4'd0;
        end else begin
            state   <= state_d;
            mode    <= state_mode(state_d, err_d);
            err     <= err_d;
            dwell_q <= dwell_d;
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            cycles <= 16'd0;
        else if (clear_req)
            cycles <= 16'd0;
        else if (state == ST_DWELL_LO && state_d == ST_RISE && cycles != 16'hFFFF)
            cycles <= cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_updown_sequencer.sv
// tb/tb_updown_sequencer.sv - directed self-checking bench for updown_sequencer with a behavioural counter model
module tb_updown_sequencer;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        clear_req = 1'b0;
    logic [7:0]  hi_lim = 8'd5;
    logic [7:0]  lo_lim = 8'd2;
    logic [3:0]  dwell = 4'd0;
    logic [7:0]  count;
    logic        tick;
    logic [1:0]  mode;
    logic [2:0]  state;
    logic        err;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    updown_sequencer #(.TICK_DIV(TDIV)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .run        (run),
        .clear_req  (clear_req),
        .hi_lim     (hi_lim),
        .lo_lim     (lo_lim),
        .dwell      (dwell),
        .count      (count),
        .tick       (tick),
        .mode       (mode),
        .state      (state),
        .err        (err)
`ifdef SEQ_CYCLE_COUNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Counter datapath model: applies mode at the end of each tick cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 8'd0;
        else if (tick) begin
            case (mode)
                2'b01:   count <= count + 8'd1;
                2'b10:   count <= count - 8'd1;
                2'b11:   count <= 8'd0;
                default: count <= count;
            endcase
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 4 * TDIV && !found; i++) begin
            @(negedge clk);
            if (tick === 1'b1)
                found = 1'b1;
        end
    endtask

    task automatic expect_ticks(input string tag, input int n, input logic [1:0] m,
                                input int c0, input int step);
        bit         found;
        logic [7:0] ec;
        for (int i = 0; i < n; i++) begin
            ec = 8'(c0 + i * step);
            wait_tick(found);
            check({tag, "_tick"}, {15'd0, found}, 16'd1);
            check({tag, "_mode"}, {14'd0, mode}, {14'd0, m});
            check({tag, "_count"}, {8'd0, count}, {8'd0, ec});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        clear_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", {13'd0, state}, 16'd0);
        check("rst_mode", {14'd0, mode}, 16'd0);
        check("rst_tick", {15'd0, tick}, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);

        // Sweep lo=2 hi=5 dwell=0
        rst_n = 1'b1;
        run = 1'b1;
        expect_ticks("t1_clear", 1, 2'b11, 0, 0);
        expect_ticks("t1_rise", 5, 2'b01, 0, 1);
        expect_ticks("t1_fall", 3, 2'b10, 5, -1);
        expect_ticks("t1_rise2", 1, 2'b01, 2, 1);

        // Asynchronous reset mid-sweep
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", {13'd0, state}, 16'd0);
        check("arst_mode", {14'd0, mode}, 16'd0);
        check("arst_tick", {15'd0, tick}, 16'd0);

        // Dwell of 3 ticks at each limit
        hi_lim = 8'd4;
        lo_lim = 8'd1;
        dwell = 4'd3;
        do_reset();
        run = 1'b1;
        expect_ticks("t2_clear", 1, 2'b11, 0, 0);
        expect_ticks("t2_rise", 4, 2'b01, 0, 1);
        expect_ticks("t2_dwhi", 3, 2'b00, 4, 0);
        expect_ticks("t2_fall", 3, 2'b10, 4, -1);
        expect_ticks("t2_dwlo", 3, 2'b00, 1, 0);
        expect_ticks("t2_rise2", 1, 2'b01, 1, 1);

        // run dropped mid-RISE at count 3
        hi_lim = 8'd6;
        lo_lim = 8'd1;
        dwell = 4'd0;
        do_reset();
        run = 1'b1;
        expect_ticks("t3_clear", 1, 2'b11, 0, 0);
        expect_ticks("t3_rise", 3, 2'b01, 0, 1);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("t3_state_idle", {13'd0, state}, 16'd0);
        check("t3_mode_hold", {14'd0, mode}, 16'd0);
        expect_ticks("t3_idle", 5, 2'b00, 3, 0);

        // clear_req with run falling during FALL
        run = 1'b1;
        expect_ticks("t4_clear", 1, 2'b11, 3, 0);
        expect_ticks("t4_rise", 6, 2'b01, 0, 1);
        expect_ticks("t4_fall", 1, 2'b10, 6, -1);
        @(negedge clk);
        check("t4_in_fall", {13'd0, state}, 16'd4);
        clear_req = 1'b1;
        run = 1'b0;
        @(negedge clk);
        clear_req = 1'b0;
        check("t4_state_clear", {13'd0, state}, 16'd1);
        check("t4_mode_clear", {14'd0, mode}, 16'd3);
        expect_ticks("t4_clrtick", 1, 2'b11, 5, 0);
        @(negedge clk);
        check("t4_state_idle", {13'd0, state}, 16'd0);
        expect_ticks("t4_idle", 1, 2'b00, 0, 0);

        // Invalid limits freeze the sweep, valid limits resume it
        run = 1'b1;
        expect_ticks("t5_clear", 1, 2'b11, 0, 0);
        expect_ticks("t5_rise", 2, 2'b01, 0, 1);
        lo_lim = 8'd7;
        hi_lim = 8'd7;
        @(negedge clk);
        check("t5_err_set", {15'd0, err}, 16'd1);
        check("t5_err_mode", {14'd0, mode}, 16'd0);
        check("t5_err_state", {13'd0, state}, 16'd2);
        expect_ticks("t5_frozen", 3, 2'b00, 2, 0);
        hi_lim = 8'd9;
        @(negedge clk);
        check("t5_err_clr", {15'd0, err}, 16'd0);
        check("t5_resume_mode", {14'd0, mode}, 16'd1);
        expect_ticks("t5_rise2", 7, 2'b01, 2, 1);
        expect_ticks("t5_fall", 2, 2'b10, 9, -1);
        expect_ticks("t5_rise3", 1, 2'b01, 7, 1);

`ifdef SEQ_CYCLE_COUNT_EN
        // Round-trip counter
        lo_lim = 8'd0;
        hi_lim = 8'd2;
        dwell = 4'd0;
        do_reset();
        check("t6_cyc_rst", cycles, 16'd0);
        run = 1'b1;
        expect_ticks("t6_clear", 1, 2'b11, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_ticks("t6_rise", 2, 2'b01, 0, 1);
            expect_ticks("t6_fall", 2, 2'b10, 2, -1);
        end
        repeat (3) @(negedge clk);
        check("t6_cyc3", cycles, 16'd3);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        check("t6_cyc_clr", cycles, 16'd0);
        check("t6_state_clr", {13'd0, state}, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
